// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters, sync pulses with
// selectable polarity, display enable, block-scaled coordinates, line/frame
// strobes and a completed-frame counter, advanced by a clock-enable prescaler.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_BP        = 64,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 23,
    parameter bit H_POL       = 1'b1,
    parameter bit V_POL       = 1'b1,
    parameter int CLK_DIV     = 1,
    parameter int SCALE_SHIFT = 3,
    parameter int H_W         = 12,
    parameter int V_W         = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    output logic           pix_ce,
    output logic [H_W-1:0] h_count,
    output logic [V_W-1:0] v_count,
    output logic [H_W-1:0] h_blk,
    output logic [V_W-1:0] v_blk,
    output logic           disp_en,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start,
    output logic [7:0]     frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]  presc;
    logic           tick;
    logic           h_wrap;
    logic           v_wrap;
    logic [H_W-1:0] h_nxt;
    logic [V_W-1:0] v_nxt;
    logic [7:0]     fc_nxt;

    // Next-count computation; all decoded outputs are registered from these
    // values so they line up with h_count/v_count in the same cycle.
    always_comb begin
        tick   = enable && (presc == PRE_LAST);
        h_wrap = tick && (h_count == H_LAST);
        v_wrap = h_wrap && (v_count == V_LAST);
        h_nxt  = h_count;
        v_nxt  = v_count;
        fc_nxt = frame_cnt;
        if (tick) begin
            if (h_wrap) begin
                h_nxt = '0;
                if (v_wrap) begin
                    v_nxt  = '0;
                    fc_nxt = frame_cnt + 8'd1;
                end else begin
                    v_nxt = v_count + V_W'(1);
                end
            end else begin
                h_nxt = h_count + H_W'(1);
            end
        end
    end

    // Prescaler, counters, decoded timing outputs and strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            pix_ce      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            h_blk       <= '0;
            v_blk       <= '0;
            disp_en     <= 1'b1;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            presc       <= (enable && !tick) ? presc + PW'(1) : '0;
            pix_ce      <= tick;
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            frame_cnt   <= fc_nxt;
            h_blk       <= h_nxt >> SCALE_SHIFT;
            v_blk       <= v_nxt >> SCALE_SHIFT;
            disp_en     <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hsync       <= ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? H_POL : ~H_POL;
            vsync       <= ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? V_POL : ~V_POL;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one default-parameter instance for line
// timing, a small-frame instance for frame-level behaviour, and a small-frame
// CLK_DIV=2 inverted-polarity instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    always #5 clk = ~clk;

    // default instance
    logic        d_pce, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [11:0] d_h, d_hb;
    logic [10:0] d_v, d_vb;
    logic [7:0]  d_fc;

    // small frame: 30 x 17, CLK_DIV=1, active-high syncs
    logic       s_pce, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [7:0] s_h, s_hb, s_v, s_vb, s_fc;

    // small frame: 30 x 17, CLK_DIV=2, active-low syncs
    logic       p_pce, p_hs, p_vs, p_de, p_ls, p_fs;
    logic [7:0] p_h, p_hb, p_v, p_vb, p_fc;

    vga_timing_gen u_d (
        .clk(clk), .reset(reset), .enable(enable), .pix_ce(d_pce),
        .h_count(d_h), .v_count(d_v), .h_blk(d_hb), .v_blk(d_vb),
        .disp_en(d_de), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls),
        .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .SCALE_SHIFT(2),
        .H_W(8), .V_W(8)
    ) u_s (
        .clk(clk), .reset(reset), .enable(enable), .pix_ce(s_pce),
        .h_count(s_h), .v_count(s_v), .h_blk(s_hb), .v_blk(s_vb),
        .disp_en(s_de), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
        .frame_start(s_fs), .frame_cnt(s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(2), .SCALE_SHIFT(2),
        .H_W(8), .V_W(8)
    ) u_p (
        .clk(clk), .reset(reset), .enable(enable), .pix_ce(p_pce),
        .h_count(p_h), .v_count(p_v), .h_blk(p_hb), .v_blk(p_vb),
        .disp_en(p_de), .hsync(p_hs), .vsync(p_vs), .line_start(p_ls),
        .frame_start(p_fs), .frame_cnt(p_fc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one rising edge, then sample at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int n;
        int sh, sv, sde, shs, svs, sls, sfs, sfc, shb, svb;
        int ph, pv, pce, phs, pvs;
    } vec_t;

    localparam int NV = 26;
    vec_t vec [NV];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        bit found;
        int ls1, ls2, hs_cnt, hs_min, hs_max, de799, de800, hb799;

        //          n   sh sv de hs vs ls fs fc hb vb   ph pv ce phs pvs
        vec[0]  = '{1,    1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1};
        vec[1]  = '{15,  15, 0, 1, 0, 0, 0, 0, 0, 3, 0,   7, 0, 0, 1, 1};
        vec[2]  = '{16,  16, 0, 0, 0, 0, 0, 0, 0, 4, 0,   8, 0, 1, 1, 1};
        vec[3]  = '{19,  19, 0, 0, 0, 0, 0, 0, 0, 4, 0,   9, 0, 0, 1, 1};
        vec[4]  = '{20,  20, 0, 0, 1, 0, 0, 0, 0, 5, 0,  10, 0, 1, 1, 1};
        vec[5]  = '{25,  25, 0, 0, 1, 0, 0, 0, 0, 6, 0,  12, 0, 0, 1, 1};
        vec[6]  = '{26,  26, 0, 0, 0, 0, 0, 0, 0, 6, 0,  13, 0, 1, 1, 1};
        vec[7]  = '{29,  29, 0, 0, 0, 0, 0, 0, 0, 7, 0,  14, 0, 0, 1, 1};
        vec[8]  = '{30,   0, 1, 1, 0, 0, 1, 0, 0, 0, 0,  15, 0, 1, 1, 1};
        vec[9]  = '{31,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  15, 0, 0, 1, 1};
        vec[10] = '{41,  11, 1, 1, 0, 0, 0, 0, 0, 2, 0,  20, 0, 0, 0, 1};
        vec[11] = '{51,  21, 1, 0, 1, 0, 0, 0, 0, 5, 0,  25, 0, 0, 0, 1};
        vec[12] = '{53,  23, 1, 0, 1, 0, 0, 0, 0, 5, 0,  26, 0, 0, 1, 1};
        vec[13] = '{300,  0,10, 0, 0, 0, 1, 0, 0, 0, 2,   0, 5, 1, 1, 1};
        vec[14] = '{315, 15,10, 0, 0, 0, 0, 0, 0, 3, 2,   7, 5, 0, 1, 1};
        vec[15] = '{360,  0,12, 0, 0, 1, 1, 0, 0, 0, 3,   0, 6, 1, 1, 1};
        vec[16] = '{449, 29,14, 0, 0, 1, 0, 0, 0, 7, 3,  14, 7, 0, 1, 1};
        vec[17] = '{450,  0,15, 0, 0, 0, 1, 0, 0, 0, 3,  15, 7, 1, 1, 1};
        vec[18] = '{509, 29,16, 0, 0, 0, 0, 0, 0, 7, 4,  14, 8, 0, 1, 1};
        vec[19] = '{510,  0, 0, 1, 0, 0, 1, 1, 1, 0, 0,  15, 8, 1, 1, 1};
        vec[20] = '{511,  1, 0, 1, 0, 0, 0, 0, 1, 0, 0,  15, 8, 0, 1, 1};
        vec[21] = '{719, 29, 6, 0, 0, 0, 0, 0, 1, 7, 1,  29,11, 0, 1, 1};
        vec[22] = '{720,  0, 7, 1, 0, 0, 1, 0, 1, 0, 1,   0,12, 1, 1, 0};
        vec[23] = '{899, 29,12, 0, 0, 1, 0, 0, 1, 7, 3,  29,14, 0, 1, 0};
        vec[24] = '{900,  0,13, 0, 0, 1, 1, 0, 1, 0, 3,   0,15, 1, 1, 1};
        vec[25] = '{1020, 0, 0, 1, 0, 0, 1, 1, 2, 0, 0,   0, 0, 1, 1, 1};

        // ---------------- reset values
        reset  = 1'b1;
        enable = 1'b0;
        #2;
        chk("rst_s_h", int'(s_h), 0);
        chk("rst_s_v", int'(s_v), 0);
        chk("rst_s_de", int'(s_de), 1);
        chk("rst_s_hs", int'(s_hs), 0);
        chk("rst_s_vs", int'(s_vs), 0);
        chk("rst_s_ls", int'(s_ls), 0);
        chk("rst_s_fs", int'(s_fs), 0);
        chk("rst_s_fc", int'(s_fc), 0);
        chk("rst_s_pce", int'(s_pce), 0);
        chk("rst_p_hs", int'(p_hs), 1);
        chk("rst_p_vs", int'(p_vs), 1);
        chk("rst_d_de", int'(d_de), 1);
        step();
        step();
        reset  = 1'b0;
        enable = 1'b1;
        n = 0;

        // ---------------- table walk through two small frames
        for (int i = 0; i < NV; i++) begin
            while (n < vec[i].n) begin
                step();
                n++;
            end
            chk($sformatf("v%0d_s_h", vec[i].n), int'(s_h), vec[i].sh);
            chk($sformatf("v%0d_s_v", vec[i].n), int'(s_v), vec[i].sv);
            chk($sformatf("v%0d_s_de", vec[i].n), int'(s_de), vec[i].sde);
            chk($sformatf("v%0d_s_hs", vec[i].n), int'(s_hs), vec[i].shs);
            chk($sformatf("v%0d_s_vs", vec[i].n), int'(s_vs), vec[i].svs);
            chk($sformatf("v%0d_s_ls", vec[i].n), int'(s_ls), vec[i].sls);
            chk($sformatf("v%0d_s_fs", vec[i].n), int'(s_fs), vec[i].sfs);
            chk($sformatf("v%0d_s_fc", vec[i].n), int'(s_fc), vec[i].sfc);
            chk($sformatf("v%0d_s_hb", vec[i].n), int'(s_hb), vec[i].shb);
            chk($sformatf("v%0d_s_vb", vec[i].n), int'(s_vb), vec[i].svb);
            chk($sformatf("v%0d_p_h", vec[i].n), int'(p_h), vec[i].ph);
            chk($sformatf("v%0d_p_v", vec[i].n), int'(p_v), vec[i].pv);
            chk($sformatf("v%0d_p_pce", vec[i].n), int'(p_pce), vec[i].pce);
            chk($sformatf("v%0d_p_hs", vec[i].n), int'(p_hs), vec[i].phs);
            chk($sformatf("v%0d_p_vs", vec[i].n), int'(p_vs), vec[i].pvs);
        end

        // ---------------- asynchronous reset mid-frame
        while (n < 1285) begin
            step();
            n++;
        end
        chk("pre_rst_s_h", int'(s_h), 25);
        chk("pre_rst_s_v", int'(s_v), 8);
        chk("pre_rst_s_fc", int'(s_fc), 2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_s_h", int'(s_h), 0);
        chk("arst_s_v", int'(s_v), 0);
        chk("arst_s_fc", int'(s_fc), 0);
        chk("arst_s_de", int'(s_de), 1);
        chk("arst_s_hs", int'(s_hs), 0);
        chk("arst_s_pce", int'(s_pce), 0);
        chk("arst_p_hs", int'(p_hs), 1);
        chk("arst_d_h", int'(d_h), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            step();
            cnt++;
            if (s_fs) found = 1'b1;
        end
        chk("arst_first_fs_delay", found ? cnt : -1, 510);
        chk("arst_fc_after_frame", int'(s_fc), 1);

        // ---------------- default-parameter line timing (d now at h=510)
        ls1 = -1; ls2 = -1;
        hs_cnt = 0; hs_min = 9999; hs_max = -1;
        de799 = -1; de800 = -1; hb799 = -1;
        cnt = 510;
        for (int k = 0; k < 1700 && ls2 < 0; k++) begin
            step();
            cnt++;
            if (d_ls) begin
                if (ls1 < 0) ls1 = cnt;
                else ls2 = cnt;
            end
            if (ls1 >= 0 && ls2 < 0 && d_hs) begin
                hs_cnt++;
                if (int'(d_h) < hs_min) hs_min = int'(d_h);
                if (int'(d_h) > hs_max) hs_max = int'(d_h);
            end
            if (d_h == 12'd799 && de799 < 0) begin
                de799 = int'(d_de);
                hb799 = int'(d_hb);
            end
            if (d_h == 12'd800 && de800 < 0) de800 = int'(d_de);
        end
        chk("d_first_ls_cycle", ls1, 1040);
        chk("d_line_period", (ls2 < 0) ? -1 : ls2 - ls1, 1040);
        chk("d_hs_width", hs_cnt, 120);
        chk("d_hs_first_h", hs_min, 856);
        chk("d_hs_last_h", hs_max, 975);
        chk("d_de_h799", de799, 1);
        chk("d_de_h800", de800, 0);
        chk("d_hblk_h799", hb799, 99);

        // ---------------- enable freeze at d h=400
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 400; k++) step();
        chk("frz_pre_d_h", int'(d_h), 400);
        enable = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("frz_d_h", int'(d_h), 400);
            chk("frz_d_v", int'(d_v), 0);
            chk("frz_d_de", int'(d_de), 1);
            chk("frz_d_pce", int'(d_pce), 0);
            chk("frz_d_ls", int'(d_ls), 0);
            chk("frz_s_h", int'(s_h), 10);
            chk("frz_s_v", int'(s_v), 13);
            chk("frz_s_vs", int'(s_vs), 1);
            chk("frz_s_pce", int'(s_pce), 0);
            chk("frz_p_h", int'(p_h), 20);
            chk("frz_p_pce", int'(p_pce), 0);
            chk("frz_p_hs", int'(p_hs), 0);
        end
        enable = 1'b1;
        step();
        chk("res_d_h", int'(d_h), 401);
        chk("res_d_pce", int'(d_pce), 1);
        chk("res_s_h", int'(s_h), 11);
        chk("res_p_h1", int'(p_h), 20);
        chk("res_p_pce1", int'(p_pce), 0);
        // p prescaler is mid-count here; a short freeze must clear it
        enable = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("frz2_d_h", int'(d_h), 401);
        chk("frz2_p_h", int'(p_h), 20);
        enable = 1'b1;
        step();
        chk("res2_p_h1", int'(p_h), 20);
        chk("res2_p_pce1", int'(p_pce), 0);
        chk("res2_d_h", int'(d_h), 402);
        step();
        chk("res2_p_h2", int'(p_h), 21);
        chk("res2_p_pce2", int'(p_pce), 1);
        chk("res2_s_h", int'(s_h), 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 800x600 VGA counter. Generates horizontal/vertical pixel counters, sync pulses with configurable polarity, display enable, and block-scaled coordinates for VRAM addressing. Also produces line/frame strobes and a frame counter. A clock-enable prescaler allows pixel clocks below clk. Sits between the board clock and the VRAM read port / VGA pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
H_POL, 1, hsync active level (1 = active-high)
V_POL, 1, vsync active level
CLK_DIV, 1, clk cycles per pixel (>=1)
SCALE_SHIFT, 3, right-shift applied to coordinates for h_blk/v_blk
H_W, 12, h_count width
V_W, 11, v_count width

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run control; low freezes timing
pix_ce  out  1  pixel clock-enable strobe
h_count  out  H_W  current pixel column, 0..H_TOTAL-1
v_count  out  V_W  current line, 0..V_TOTAL-1
h_blk  out  H_W  h_count >> SCALE_SHIFT
v_blk  out  V_W  v_count >> SCALE_SHIFT
disp_en  out  1  pixel (h_count, v_count) is in the visible area
hsync  out  1  horizontal sync, polarity per H_POL
vsync  out  1  vertical sync, polarity per V_POL
line_start  out  1  one-clk pulse on entry to h_count=0
frame_start  out  1  one-clk pulse on entry to (0,0)
frame_cnt  out  8  completed-frame counter

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666).
- Clock reset is asynchronous and active-high. All outputs and state are registered.
- Reset values: h_count=0, v_count=0, h_blk=0, v_blk=0, disp_en=1, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0, frame_cnt=0, pix_ce=0, prescaler=0.
- Prescaler: counts 0..CLK_DIV-1 while enable=1. pix_ce=1 in the cycle where the prescaler equals CLK_DIV-1. With CLK_DIV=1, pix_ce=enable, registered (1 from the first enabled cycle after reset).
- Counter advance on each pix_ce cycle:
  - h_count increments.
  - At h_count=H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - At v_count=V_TOTAL-1 together with the h wrap, v_count wraps to 0 and frame_cnt increments (modulo 256, 255→0).
- Decode: hsync, vsync, disp_en, h_blk and v_blk are computed from the next count values, so they are aligned with h_count/v_count in the same cycle (zero relative latency).
  - disp_en = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hsync = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~V_POL. vsync is line-based and changes together with h_count wrapping to 0.
- line_start: high for exactly one clk, in the cycle h_count becomes 0 via a wrap. Not asserted out of reset.
- frame_start: high for exactly one clk, in the cycle (h,v) becomes (0,0) via a wrap. Coincides with line_start and the frame_cnt update.
- enable=0:
  - pix_ce=0 and the prescaler clears to 0.
  - Counts, syncs, disp_en, blk outputs and frame_cnt hold.
  - Strobes are 0.
  - On re-enable, the next pix_ce occurs after CLK_DIV cycles.
- Reset mid-frame: immediate asynchronous return to reset values. Counting restarts from (0,0) with no frame_start pulse.
- Parameter legality: H_TOTAL < 2^H_W, V_TOTAL < 2^V_W, all porch/sync parameters >= 1. Illegal sets are out of scope; no runtime checking.

Test Plan:
- Defaults, enable=1 after reset:
  - disp_en=1 for h_count 0..799, 0 at h_count=800.
  - hsync=1 exactly for h_count 856..975 (120 clks).
  - line_start period = 1040 clks.
- Defaults, full frame:
  - vsync=1 for v_count 637..642 (6 lines = 6240 clks).
  - frame_start period = 692,640 clks.
  - frame_cnt 0→1 at the first frame_start.
  - v_blk=75 at v_count 600; h_blk=99 at h_count 799.
- CLK_DIV=2:
  - pix_ce toggles every other clk.
  - line_start period = 2080 clks; h_count holds each value for 2 clks.
- H_POL=0, V_POL=0:
  - hsync idles at 1 and goes 0 for h_count 856..975.
  - vsync idles at 1 and goes 0 for lines 637..642.
  - Reset values are hsync=1, vsync=1.
- enable deasserted at h_count=400 for 50 clks:
  - All outputs frozen; pix_ce=0; no strobes.
  - Resumes at h_count=401 on the first enabled pix_ce.
- reset pulsed at (h,v)=(900,300), asynchronously mid-cycle:
  - Outputs immediately take reset values; frame_cnt=0.
  - No frame_start until a full 692,640-clk frame completes.
